// File: rtl/bram_sdp_pkg.sv
// Shared types and helpers for the bram_sdp block RAM wrapper and its array core.
// The optional parity feature in this block is enabled with BRAM_PARITY_EN.
package bram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } bram_state_e;

   localparam int MAX_LANE_W = 64;

   function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
      return ^lane;
   endfunction

   function automatic bit cfg_ok(input int width, input int byte_w, input int depth,
                                 input int rd_lat);
      return (byte_w > 0) && (byte_w < MAX_LANE_W) && (width % byte_w == 0) &&
             (depth >= 2) && ((rd_lat == 1) || (rd_lat == 2));
   endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Raw storage array: per-lane write enables and a registered, read-first read port.
// Kept free of reset and bypass logic so it maps onto block RAM.
module bram_sdp_core #(
   parameter int LANE_W = 9,
   parameter int NB     = 8,
   parameter int DEPTH  = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [NB-1:0]        i_be,
   input  logic [AW-1:0]        i_waddr,
   input  logic [NB*LANE_W-1:0] i_wdata,
   input  logic                 i_re,
   input  logic [AW-1:0]        i_raddr,
   output logic [NB*LANE_W-1:0] o_rdata
);

   (* ram_style = "block" *) logic [NB*LANE_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int i = 0; i < NB; i++) begin
            if (i_be[i]) r_mem[i_waddr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
         end
      end
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM wrapper: post-reset clear sweep, collision merge, 1/2-cycle read
// pipeline with valid. Define BRAM_PARITY_EN for per-lane even parity and o_par_err.
module bram_sdp
   import bram_pkg::*;
#(
   parameter  int WIDTH        = 72,
   parameter  int BYTE_W       = 9,
   parameter  int DEPTH        = 256,
   parameter  int RD_LAT       = 1,
   parameter  int BYPASS       = 1,
   parameter  int CLEAR_ON_RST = 1,
   localparam int NB           = WIDTH / BYTE_W,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_waddr,
   input  logic [NB-1:0]    i_wbe,
   input  logic             i_wen,
   input  logic [AW-1:0]    i_raddr,
   input  logic             i_ren,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_rvalid,
`ifdef BRAM_PARITY_EN
   output logic             o_init_busy,
   output logic [NB-1:0]    o_par_err
`else
   output logic             o_init_busy
`endif
);

`ifdef BRAM_PARITY_EN
   localparam int LW = BYTE_W + 1;
`else
   localparam int LW = BYTE_W;
`endif

   if (!cfg_ok(WIDTH, BYTE_W, DEPTH, RD_LAT)) begin : g_bad_cfg
      $error("bram_sdp: WIDTH must be a multiple of BYTE_W, DEPTH >= 2, RD_LAT 1 or 2");
   end

   bram_state_e        r_state;
   bram_state_e        w_state_nxt;
   logic [AW-1:0]      r_clr_addr;
   logic               w_ready;
   logic               w_wen;
   logic               w_ren;
   logic               w_core_we;
   logic [NB-1:0]      w_core_be;
   logic [AW-1:0]      w_core_waddr;
   logic [NB*LW-1:0]   w_core_wdata;
   logic [NB*LW-1:0]   w_core_rdata;
   logic               r_vld_p1;
   logic               r_hit_p1;
   logic [NB-1:0]      r_wbe_p1;
   logic [WIDTH-1:0]   r_wdata_p1;
   logic [NB-1:0]      w_fwd;
   logic [WIDTH-1:0]   w_merged;
`ifdef BRAM_PARITY_EN
   logic [NB-1:0]      w_perr;
`endif

   assign w_ready     = (r_state == READY);
   assign w_wen       = i_wen & w_ready;
   assign w_ren       = i_ren & w_ready;
   assign o_init_busy = (r_state == CLEAR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CLEAR:   if (r_clr_addr == AW'(DEPTH - 1)) w_state_nxt = READY;
         default: w_state_nxt = READY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              r_clr_addr <= '0;
      else if (r_state == CLEAR) r_clr_addr <= r_clr_addr + AW'(1);
   end

   // The sweep owns the write port while clearing: all lanes, zero data, zero parity.
   assign w_core_we    = ~w_ready | w_wen;
   assign w_core_be    = w_ready ? i_wbe : '1;
   assign w_core_waddr = w_ready ? i_waddr : r_clr_addr;

   always_comb begin
      w_core_wdata = '0;
      if (w_ready) begin
         for (int i = 0; i < NB; i++) begin
            w_core_wdata[i*LW +: BYTE_W] = i_wdata[i*BYTE_W +: BYTE_W];
`ifdef BRAM_PARITY_EN
            w_core_wdata[i*LW + BYTE_W] = lane_parity(MAX_LANE_W'(i_wdata[i*BYTE_W +: BYTE_W]));
`endif
         end
      end
   end

   bram_sdp_core #(
      .LANE_W (LW),
      .NB     (NB),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_core (
      .i_clk   (i_clk),
      .i_we    (w_core_we),
      .i_be    (w_core_be),
      .i_waddr (w_core_waddr),
      .i_wdata (w_core_wdata),
      .i_re    (w_ren),
      .i_raddr (i_raddr),
      .o_rdata (w_core_rdata)
   );

   // ---- stage p1: array read in flight, collision info registered alongside ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld_p1   <= 1'b0;
         r_hit_p1   <= 1'b0;
         r_wbe_p1   <= '0;
         r_wdata_p1 <= '0;
      end else begin
         r_vld_p1   <= w_ren;
         r_hit_p1   <= w_wen & w_ren & (i_waddr == i_raddr);
         r_wbe_p1   <= i_wbe;
         r_wdata_p1 <= i_wdata;
      end
   end

   always_comb begin
      w_fwd    = '0;
      w_merged = '0;
`ifdef BRAM_PARITY_EN
      w_perr   = '0;
`endif
      for (int i = 0; i < NB; i++) begin
         w_fwd[i] = (BYPASS != 0) && r_hit_p1 && r_wbe_p1[i];
         w_merged[i*BYTE_W +: BYTE_W] = w_fwd[i] ? r_wdata_p1[i*BYTE_W +: BYTE_W]
                                                 : w_core_rdata[i*LW +: BYTE_W];
`ifdef BRAM_PARITY_EN
         w_perr[i] = ~w_fwd[i] & (w_core_rdata[i*LW + BYTE_W] !=
                     lane_parity(MAX_LANE_W'(w_core_rdata[i*LW +: BYTE_W])));
`endif
      end
   end

   // ---- stage p2 (RD_LAT=2) or hold register (RD_LAT=1) ----
   if (RD_LAT == 2) begin : g_lat2
      logic             r_vld_p2;
      logic [WIDTH-1:0] r_rdata_p2;
`ifdef BRAM_PARITY_EN
      logic [NB-1:0]    r_perr_p2;
`endif
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_vld_p2   <= 1'b0;
            r_rdata_p2 <= '0;
`ifdef BRAM_PARITY_EN
            r_perr_p2  <= '0;
`endif
         end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_rdata_p2 <= w_merged;
`ifdef BRAM_PARITY_EN
            r_perr_p2 <= r_vld_p1 ? w_perr : '0;
`endif
         end
      end
      assign o_rvalid = r_vld_p2;
      assign o_rdata  = r_rdata_p2;
`ifdef BRAM_PARITY_EN
      assign o_par_err = r_perr_p2;
`endif
   end else begin : g_lat1
      logic [WIDTH-1:0] r_rdata_hold;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)      r_rdata_hold <= '0;
         else if (r_vld_p1) r_rdata_hold <= w_merged;
      end
      assign o_rvalid = r_vld_p1;
      assign o_rdata  = r_vld_p1 ? w_merged : r_rdata_hold;
`ifdef BRAM_PARITY_EN
      assign o_par_err = r_vld_p1 ? w_perr : '0;
`endif
   end

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: two instances (RD_LAT=1/BYPASS=1 and RD_LAT=2/BYPASS=0) driven
// with the same directed and random traffic, checked against an array/queue model.
module tb_bram_sdp;

   localparam int W  = 72;
   localparam int NB = 8;
   localparam int D  = 256;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   wdata;
   logic [7:0]     waddr;
   logic [NB-1:0]  wbe;
   logic           wen;
   logic [7:0]     raddr;
   logic           ren;
   logic [W-1:0]   rdata0, rdata1;
   logic           rvalid0, rvalid1, busy0, busy1;
`ifdef BRAM_PARITY_EN
   logic [NB-1:0]  perr0, perr1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bram_sdp #(.RD_LAT(1), .BYPASS(1)) u_d0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wdata(wdata), .i_waddr(waddr), .i_wbe(wbe),
      .i_wen(wen), .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata0), .o_rvalid(rvalid0),
`ifdef BRAM_PARITY_EN
      .o_init_busy(busy0), .o_par_err(perr0)
`else
      .o_init_busy(busy0)
`endif
   );

   bram_sdp #(.RD_LAT(2), .BYPASS(0)) u_d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wdata(wdata), .i_waddr(waddr), .i_wbe(wbe),
      .i_wen(wen), .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata1), .o_rvalid(rvalid1),
`ifdef BRAM_PARITY_EN
      .o_init_busy(busy1), .o_par_err(perr1)
`else
      .o_init_busy(busy1)
`endif
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: word array, lane-0 corruption marks, expected-read queues.
   typedef struct {
      int            due;
      logic [W-1:0]  d;
      logic [NB-1:0] pe;
   } rd_t;

   logic [W-1:0] mem [D];
   bit           corrupt [D];
   rd_t          q0[$];
   rd_t          q1[$];
   logic [W-1:0] hold0, hold1;
   int           ncyc;

   function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] wd,
                                          input logic [NB-1:0] be);
      logic [W-1:0] m;
      m = old;
      for (int i = 0; i < NB; i++) if (be[i]) m[i*9 +: 9] = wd[i*9 +: 9];
      return m;
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   task automatic drive_idle();
      wen = 1'b0; waddr = '0; wbe = '0; wdata = '0; ren = 1'b0; raddr = '0;
   endtask

   task automatic do_reset(input int hold_cycles);
      rst_n = 1'b0;
      drive_idle();
      #1;
      check("rst_rdata0", rdata0, '0);
      check("rst_rdata1", rdata1, '0);
      check("rst_rvalid0", rvalid0, 1'b0);
      check("rst_rvalid1", rvalid1, 1'b0);
      check("rst_busy0", busy0, 1'b1);
      check("rst_busy1", busy1, 1'b1);
`ifdef BRAM_PARITY_EN
      check("rst_perr0", perr0, '0);
      check("rst_perr1", perr1, '0);
`endif
      repeat (hold_cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ncyc  = 0;
      q0.delete();
      q1.delete();
      hold0 = '0;
      hold1 = '0;
      for (int a = 0; a < D; a++) begin
         mem[a]     = '0;
         corrupt[a] = 1'b0;
      end
   endtask

   task automatic step(input logic w, input logic [7:0] wa, input logic [NB-1:0] be,
                       input logic [W-1:0] wd, input logic r, input logic [7:0] ra);
      rd_t e;
      @(posedge clk);
      #1;
      ncyc++;
      check("busy0", busy0, (ncyc < D));
      check("busy1", busy1, (ncyc < D));
      if (q0.size() != 0 && q0[0].due == ncyc) begin
         check("rvalid0", rvalid0, 1'b1);
         check("rdata0", rdata0, q0[0].d);
`ifdef BRAM_PARITY_EN
         check("perr0", perr0, q0[0].pe);
`endif
         hold0 = q0[0].d;
         void'(q0.pop_front());
      end else begin
         check("rvalid0_idle", rvalid0, 1'b0);
         check("rdata0_hold", rdata0, hold0);
      end
      if (q1.size() != 0 && q1[0].due == ncyc) begin
         check("rvalid1", rvalid1, 1'b1);
         check("rdata1", rdata1, q1[0].d);
`ifdef BRAM_PARITY_EN
         check("perr1", perr1, q1[0].pe);
`endif
         hold1 = q1[0].d;
         void'(q1.pop_front());
      end else begin
         check("rvalid1_idle", rvalid1, 1'b0);
         check("rdata1_hold", rdata1, hold1);
      end

      wen = w; waddr = wa; wbe = be; wdata = wd; ren = r; raddr = ra;
      if (ncyc >= D && r) begin
         e.due = ncyc + 1;
         e.d   = mem[ra];
         e.pe  = corrupt[ra] ? NB'(1) : '0;
         if (w && wa == ra) begin
            e.d = merge(mem[ra], wd, be);
            if (be[0]) e.pe = '0;
         end
         q0.push_back(e);
         e.due = ncyc + 2;
         e.d   = mem[ra];
         e.pe  = corrupt[ra] ? NB'(1) : '0;
         q1.push_back(e);
      end
      if (ncyc >= D && w) begin
         mem[wa] = merge(mem[wa], wd, be);
         if (be[0]) corrupt[wa] = 1'b0;
      end
   endtask

   task automatic idle();
      step(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [7:0] wa, ra;
      drive_idle();
      do_reset(3);

      // reset mid-sweep at cycle 100, with ignored ren/wen pulses
      for (int i = 0; i < 100; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), '1, rnd_word(),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      do_reset(2);
      for (int i = 0; i < D; i++)
         step(1'b0, '0, '0, '0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

      // first read right after the sweep
      step(1'b0, '0, '0, '0, 1'b1, 8'hFF);
      idle();
      check("t1_rvalid", rvalid0, 1'b1);
      check("t1_rdata", rdata0, '0);
      idle();

      // byte-lane write
      step(1'b1, 8'h10, 8'hFF, '1, 1'b0, '0);
      step(1'b1, 8'h10, 8'h01, '0, 1'b0, '0);
      step(1'b0, '0, '0, '0, 1'b1, 8'h10);
      idle();
      check("t2_byte_d0", rdata0, 72'hFF_FFFF_FFFF_FFFF_FE00);
      idle();
      check("t2_byte_d1", rdata1, 72'hFF_FFFF_FFFF_FFFF_FE00);

      // collision: bypass vs read-first, then the array holds the write
      step(1'b1, 8'h20, 8'hFF, 72'h123, 1'b1, 8'h20);
      idle();
      check("t3_bypass", rdata0, 72'h123);
      idle();
      check("t3_readfirst", rdata1, 72'h0);
      step(1'b0, '0, '0, '0, 1'b1, 8'h20);
      idle();
      check("t3_after_d0", rdata0, 72'h123);
      idle();
      check("t3_after_d1", rdata1, 72'h123);

      // back-to-back reads on the two-cycle instance
      step(1'b1, 8'h01, 8'hFF, 72'hA, 1'b0, '0);
      step(1'b1, 8'h02, 8'hFF, 72'hB, 1'b0, '0);
      step(1'b1, 8'h03, 8'hFF, 72'hC, 1'b0, '0);
      step(1'b0, '0, '0, '0, 1'b1, 8'h01);
      step(1'b0, '0, '0, '0, 1'b1, 8'h02);
      step(1'b0, '0, '0, '0, 1'b1, 8'h03);
      check("t4_v_a", rvalid1, 1'b1);
      check("t4_d_a", rdata1, 72'hA);
      idle();
      check("t4_d_b", rdata1, 72'hB);
      idle();
      check("t4_d_c", rdata1, 72'hC);
      idle();
      check("t4_v_end", rvalid1, 1'b0);

`ifdef BRAM_PARITY_EN
      step(1'b1, 8'h30, 8'hFF, '0, 1'b0, '0);
      step(1'b1, 8'h31, 8'hFF, '0, 1'b0, '0);
      idle();
      u_d0.u_core.r_mem[8'h30][3] = ~u_d0.u_core.r_mem[8'h30][3];
      u_d1.u_core.r_mem[8'h30][3] = ~u_d1.u_core.r_mem[8'h30][3];
      corrupt[8'h30] = 1'b1;
      step(1'b0, '0, '0, '0, 1'b1, 8'h30);
      step(1'b0, '0, '0, '0, 1'b1, 8'h31);
      check("t6_perr_30", perr0, 8'h01);
      idle();
      check("t6_perr_31", perr0, 8'h00);
      idle();
      idle();
`endif

      // random traffic over a small address window to provoke collisions
      for (int i = 0; i < 3000; i++) begin
         wa = 8'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), wa, NB'($urandom_range(0, 255)), rnd_word(),
              1'($urandom_range(0, 1)), ra);
      end
      idle();
      idle();
      idle();

      // reset after traffic clears the outputs and restarts the sweep
      do_reset(2);
      for (int i = 0; i < D + 4; i++)
         step(1'b0, '0, '0, '0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
      idle();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bram_sdp.md
# bram_sdp

Simple-dual-port block RAM with per-byte write enables, configurable read latency (1 or 2), selectable read-during-write collision behaviour, and a hardware clear sweep after reset. It is the general-purpose storage primitive used behind FIFOs, tables and packet buffers throughout the design. It replaces simulation-only zero initialisation with a synthesizable clear and adds valid signalling on the read side.

## Interface
- `WIDTH`, 72: data width in bits; must be a multiple of `BYTE_W`.
- `BYTE_W`, 9: write-enable lane width; `NB = WIDTH/BYTE_W` lanes.
- `DEPTH`, 256: number of words, ≥2; `AW = $clog2(DEPTH)`.
- `RD_LAT`, 1: read latency, 1 or 2; any other value is an elaboration error.
- `BYPASS`, 1: 1 = write-first forwarding on address collision; 0 = read-first (old data).
- `CLEAR_ON_RST`, 1: 1 = zero the whole array after every reset.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wdata` in WIDTH: write data; lane i is `wdata[i*BYTE_W +: BYTE_W]`.
- `waddr` in AW: write address.
- `wbe` in NB: per-lane write enable.
- `wen` in 1: write strobe; writes only lanes with `wbe` set.
- `raddr` in AW: read address.
- `ren` in 1: read strobe.
- `rdata` out WIDTH: read data; holds its last value when no new read completes.
- `rvalid` out 1: one-cycle pulse per accepted read, aligned with `rdata`.
- `init_busy` out 1: high while the clear sweep runs.
- `par_err` out NB: per-lane parity error, aligned with `rvalid`. Present only with `BRAM_PARITY_EN`.

## Operation
- FSM states CLEAR and READY. Async reset enters CLEAR if `CLEAR_ON_RST=1`, otherwise READY.
- CLEAR:
  - Writes all-zero data (and zero parity) to address 0..DEPTH-1, one word per cycle, starting with the first clock after `rst_n` rises.
  - Moves to READY after writing DEPTH-1.
  - `wen` and `ren` are ignored: no write, no `rvalid`.
- READY:
  - When `wen=1`, lanes with `wbe[i]=1` are updated. `wen=1` with `wbe=0` is a no-op.
  - When `ren=1`, the read is accepted.
  - A write and a read in the same cycle to different addresses are independent.
- Collision (same cycle, `wen && ren && waddr==raddr`):
  - `BYPASS=1`: `rdata` holds the merged word, `wdata` on enabled lanes and old contents elsewhere.
  - `BYPASS=0`: `rdata` holds the full old word.
  - The array always takes the write.
- Reset does not clear array storage itself; only the sweep does. A reset mid-sweep restarts the sweep from address 0.
- Reset values: `rdata=0`, `rvalid=0`, `par_err=0`, `init_busy=1` (`CLEAR_ON_RST=1`) or 0, pipeline registers 0.
- `rvalid` is independent of `rdata` hold. There is no backpressure; every accepted read produces exactly one `rvalid`.

## Timing
- Write is visible to a read issued on the next cycle or later (1-cycle write latency).
- `RD_LAT=1`: `rvalid`/`rdata` appear on the cycle after `ren`.
- `RD_LAT=2`: `rvalid`/`rdata` appear two cycles after `ren`. This adds one output register stage.
- Full throughput: one read and one write per cycle, with back-to-back reads producing back-to-back `rvalid`.
- `init_busy` stays high for exactly DEPTH cycles after reset release, then falls. A `ren` on the cycle `init_busy` is first low is accepted.
- Collision merge happens after the array read stage, using registered `wdata`/`wbe`/hit flag. The array stays pure inference-friendly.

## Configuration
- `BRAM_PARITY_EN` defined:
  - The array stores WIDTH+NB bits, one even-parity bit per lane, computed on write.
  - On read, parity is recomputed per lane. `par_err[i]=1` with `rvalid` when lane i mismatches.
  - Forwarded (bypassed) lanes never flag an error.
  - Clear writes parity 0.
- `BRAM_PARITY_EN` undefined: no parity storage, no `par_err` port, array width is WIDTH.

## Structure
- Package `bram_pkg`:
  - State enum typedef `bram_state_e` (CLEAR, READY).
  - Function `lane_parity` (XOR-reduce of one lane).
  - Elaboration-check helper for `WIDTH % BYTE_W` and `RD_LAT`.
- Sub-module `bram_sdp_core` holds the raw array, its byte-enable write and registered read, and carries the `ram_style="block"` attribute.
- The `bram_sdp` wrapper holds the FSM, clear counter, collision merge, output pipeline and parity.

## Test plan
1. Reset release, default params: `init_busy` high exactly 256 cycles. Read 0xFF afterwards → `rdata=0`, `rvalid` 1 cycle later.
2. Byte write: write all-ones to 0x10 with `wbe=8'hFF`, then zero with `wbe=8'h01`. Read 0x10 → `72'hFF_FFFF_FFFF_FFFF_FE00`.
3. Collision: 0x20 holds 0. Write 0x123 (`wbe=8'hFF`) and read 0x20 in the same cycle → `rdata=0x123` (`BYPASS=1`) or 0 (`BYPASS=0`). The next read of 0x20 → 0x123 in both cases.
4. `RD_LAT=2`: back-to-back reads of addr 1,2,3 (preloaded 0xA,0xB,0xC) → `rvalid` high 3 consecutive cycles starting 2 cycles after the first `ren`, data 0xA,0xB,0xC.
5. Reset mid-sweep: assert `rst_n=0` at sweep cycle 100, release. `init_busy` stays high 256 cycles from the second release. `ren` pulses during the sweep give no `rvalid`.
6. `BRAM_PARITY_EN`: write 0 to 0x30, flip bit 3 of the stored word by hierarchical deposit, read 0x30 → `par_err=8'h01` with `rvalid`. Read 0x31 → `par_err=0`.
